// File: rtl/hex_scan_pkg.sv
// Shared constants and types for the 4-digit multiplexed 7-segment controller.
package hex_scan_pkg;

    // Register map (single address bit)
    localparam logic ADR_VALUE = 1'b0;
    localparam logic ADR_CTRL  = 1'b1;

    // CTRL field positions
    localparam int CTRL_EN       = 0;
    localparam int CTRL_BLINK    = 1;
    localparam int CTRL_BLANK_LO = 4;
    localparam int CTRL_BLANK_HI = 7;

    // Implemented CTRL bits; everything else reads back as zero
    localparam logic [15:0] CTRL_MASK = 16'h00f3;

    // All segments dark (segments are active-low)
    localparam logic [6:0] SEG_OFF = 7'h7f;

    // Scan state: a digit is shown, then one all-dark clock before the next
    typedef enum logic {
        SHOW = 1'b0,
        GAP  = 1'b1
    } scan_state_t;

    // Merge new write data into an old register value under byte enables
    function automatic logic [15:0] byte_merge(input logic [15:0] old_v,
                                               input logic [15:0] new_v,
                                               input logic [1:0]  sel);
        logic [15:0] res;
        res[15:8] = sel[1] ? new_v[15:8] : old_v[15:8];
        res[7:0]  = sel[0] ? new_v[7:0]  : old_v[7:0];
        return res;
    endfunction

endpackage

// File: rtl/hex_scan_ctrl_seg_7.sv
// Hex digit to active-low 7-segment decoder, segments ordered {g,f,e,d,c,b,a}.
// When en is low every segment is dark.
module seg_7 (
    input  logic [3:0] num,
    input  logic       en,
    output logic [6:0] seg
);

    // Combinational nibble-to-segment lookup with a dark override
    always_comb begin
        seg = 7'h7f;
        if (en) begin
            case (num)
                4'h0:    seg = 7'h40;
                4'h1:    seg = 7'h79;
                4'h2:    seg = 7'h24;
                4'h3:    seg = 7'h30;
                4'h4:    seg = 7'h19;
                4'h5:    seg = 7'h12;
                4'h6:    seg = 7'h02;
                4'h7:    seg = 7'h78;
                4'h8:    seg = 7'h00;
                4'h9:    seg = 7'h10;
                4'ha:    seg = 7'h08;
                4'hb:    seg = 7'h03;
                4'hc:    seg = 7'h46;
                4'hd:    seg = 7'h21;
                4'he:    seg = 7'h06;
                4'hf:    seg = 7'h0e;
                default: seg = 7'h7f;
            endcase
        end else begin
            seg = 7'h7f;
        end
    end

endmodule

// File: rtl/hex_scan_ctrl.sv
// Wishbone slave driving a 4-digit common-anode multiplexed 7-segment display.
// VALUE holds four hex digits, CTRL holds enable, blink and per-digit blanking.
// The prescaler only advances while a digit is shown, so every digit gets a
// full SCAN_DIV clocks of on-time followed by a single all-dark guard clock.
module hex_scan_ctrl
    import hex_scan_pkg::*;
#(
    parameter int SCAN_DIV    = 50000,
    parameter int BLINK_SLOTS = 256
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_adr_i,
    input  logic [15:0] wb_dat_i,
    input  logic [1:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic [15:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic [6:0]  seg_o,
    output logic [3:0]  an_n_o
);

    localparam int              PW       = $clog2(SCAN_DIV);
    localparam int              BW       = $clog2(BLINK_SLOTS + 1);
    localparam logic [PW-1:0]   PRE_MAX  = PW'(SCAN_DIV - 1);
    localparam logic [BW-1:0]   BCNT_MAX = BW'(BLINK_SLOTS - 1);

    logic [15:0]   r_value;
    logic [15:0]   r_ctrl;
    logic [15:0]   r_dat;
    logic          r_ack;
    logic [PW-1:0] r_pre;
    logic [BW-1:0] r_bcnt;
    logic          r_phase;
    logic [1:0]    r_idx;
    scan_state_t   r_state;
    logic [6:0]    r_seg;
    logic [3:0]    r_an;

    scan_state_t   w_state_nxt;
    logic          w_req;
    logic          w_ack_nxt;
    logic          w_wr;
    logic [15:0]   w_rdata;
    logic          w_tick;
    logic          w_vis;
    logic [3:0]    w_blank;
    logic [3:0]    w_nibble;
    logic [6:0]    w_seg_dec;
    logic [6:0]    w_seg_nxt;
    logic [3:0]    w_an_nxt;

    assign w_req     = wb_stb_i & wb_cyc_i;
    assign w_ack_nxt = w_req & ~r_ack;
    assign w_wr      = r_ack & w_req & wb_we_i;
    assign w_tick    = (r_state == SHOW) && (r_pre == PRE_MAX);
    assign w_blank   = r_ctrl[CTRL_BLANK_HI:CTRL_BLANK_LO];
    assign w_nibble  = r_value[{r_idx, 2'b00} +: 4];
    assign w_vis     = r_ctrl[CTRL_EN] & ~w_blank[r_idx] & (~r_ctrl[CTRL_BLINK] | r_phase);

    assign wb_dat_o  = r_dat;
    assign wb_ack_o  = r_ack;
    assign seg_o     = r_seg;
    assign an_n_o    = r_an;

    seg_7 u_seg_7 (
        .num (w_nibble),
        .en  (w_vis),
        .seg (w_seg_dec)
    );

    // Register read mux
    always_comb begin
        w_rdata = 16'h0000;
        if (wb_adr_i == ADR_CTRL) begin
            w_rdata = r_ctrl;
        end else begin
            w_rdata = r_value;
        end
    end

    // Bus handshake: one wait state, write commits in the ack cycle, data only with ack
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack   <= 1'b0;
            r_dat   <= 16'h0000;
            r_value <= 16'h0000;
            r_ctrl  <= 16'h0000;
        end else begin
            r_ack <= w_ack_nxt;
            r_dat <= w_ack_nxt ? w_rdata : 16'h0000;
            if (w_wr && (wb_adr_i == ADR_VALUE)) begin
                r_value <= byte_merge(r_value, wb_dat_i, wb_sel_i);
            end else if (w_wr && (wb_adr_i == ADR_CTRL)) begin
                r_ctrl <= byte_merge(r_ctrl, wb_dat_i, wb_sel_i) & CTRL_MASK;
            end
        end
    end

    // Slot prescaler, paused during the guard clock
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_pre <= '0;
        end else if (r_state == SHOW) begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
        end else begin
            r_pre <= r_pre;
        end
    end

    // Scan state and digit index; the index advances when leaving the guard clock
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= SHOW;
            r_idx   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == GAP) begin
                r_idx <= r_idx + 2'd1;
            end
        end
    end

    // Next scan state and the pin values to register this cycle
    always_comb begin
        w_state_nxt = r_state;
        w_an_nxt    = 4'hf;
        w_seg_nxt   = SEG_OFF;
        case (r_state)
            SHOW: begin
                w_state_nxt = w_tick ? GAP : SHOW;
                w_an_nxt    = r_ctrl[CTRL_EN] ? ~(4'b0001 << r_idx) : 4'hf;
                w_seg_nxt   = w_seg_dec;
            end
            GAP: begin
                w_state_nxt = SHOW;
                w_an_nxt    = 4'hf;
                w_seg_nxt   = SEG_OFF;
            end
            default: begin
                w_state_nxt = SHOW;
                w_an_nxt    = 4'hf;
                w_seg_nxt   = SEG_OFF;
            end
        endcase
    end

    // Blink half-period counter, advanced on every entry into the guard clock
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_bcnt  <= '0;
            r_phase <= 1'b1;
        end else if (!r_ctrl[CTRL_BLINK]) begin
            r_bcnt  <= '0;
            r_phase <= 1'b1;
        end else if (w_tick) begin
            if (r_bcnt == BCNT_MAX) begin
                r_bcnt  <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_bcnt <= r_bcnt + 1'b1;
            end
        end else begin
            r_bcnt <= r_bcnt;
        end
    end

    // Registered display pins
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_seg <= SEG_OFF;
            r_an  <= 4'hf;
        end else begin
            r_seg <= w_seg_nxt;
            r_an  <= w_an_nxt;
        end
    end

endmodule

// File: doc/hex_scan_ctrl.md
Name: hex_scan_ctrl

Overview:
- Wishbone-slave controller for a 4-digit, common-anode, time-multiplexed 7-segment display.
- Holds a 16-bit display value and a control register.
- Scans one digit at a time through a single seg_7 instance, with a programmable scan rate, per-digit blanking, a global enable and blink.
- Sits on the peripheral Wishbone bus beside the other board I/O.

Parameters:
- SCAN_DIV, 50000: clocks per digit slot; must be ≥ 2.
- BLINK_SLOTS, 256: digit slots per blink half-period; must be ≥ 1.

Ports:
- wb_clk_i  in  1  system clock, all logic rising-edge.
- wb_rst_i  in  1  reset; synchronous, active-high.
- wb_adr_i  in  1  register select: 0 = VALUE, 1 = CTRL.
- wb_dat_i  in  16  write data.
- wb_sel_i  in  2  byte enables: [0] = bits 7:0, [1] = bits 15:8.
- wb_we_i  in  1  write strobe qualifier.
- wb_stb_i  in  1  strobe.
- wb_cyc_i  in  1  cycle.
- wb_dat_o  out  16  read data.
- wb_ack_o  out  1  acknowledge.
- seg_o  out  7  segment drive, active-low (7'h7f = dark).
- an_n_o  out  4  digit anode select, active-low one-hot or 4'hf.

Behaviour:
- Reset values:
  - VALUE = 16'h0000; CTRL = 16'h0000.
  - wb_ack_o = 0; wb_dat_o = 0.
  - seg_o = 7'h7f; an_n_o = 4'hf.
  - Prescaler = 0; digit index = 0; blink counter = 0; blink phase = 1 (visible).
- CTRL fields:
  - [0] EN: global display enable.
  - [1] BLINK: blink enable.
  - [7:4] BLANK: bit k = 1 keeps digit k dark.
  - All other bits read 0.
- Bus handshake:
  - wb_ack_o = stb & cyc & ~wb_ack_o, registered. One wait state; ack never high two consecutive cycles.
  - A write commits on the ack cycle, per byte enable.
  - wb_dat_o is registered with ack; it is 0 when ack is low.
  - A read issued the cycle after a write to the same register returns the new value.
- Prescaler: counts 0..SCAN_DIV-1 and wraps. `tick` = 1 for one clock at count SCAN_DIV-1.
- Scan FSM, states SHOW and GAP:
  - SHOW: an_n_o = ~(4'b0001 << idx), seg_o = seg_7(VALUE[4*idx+3:4*idx], vis).
  - On tick, SHOW→GAP: an_n_o = 4'hf and seg_o = 7'h7f for exactly one clock (ghosting guard), then idx = idx+1 mod 4 and GAP→SHOW.
  - Digit order is 0,1,2,3,0…; digit 0 = VALUE[3:0], driven on an_n_o[0].
- Visibility: vis = EN & ~BLANK[idx] & (~BLINK | phase).
  - When vis = 0, the anode is still asserted and seg_o = 7'h7f.
  - When EN = 0, an_n_o = 4'hf throughout and the FSM keeps running.
- Blink: counts GAP entries; after BLINK_SLOTS entries it toggles phase and clears.
  - Clearing CTRL.BLINK forces phase = 1 and clears the counter.
- Output timing: seg_o and an_n_o are registered, so one cycle of latency from idx/VALUE to the pins.
  - A VALUE write shows on the current digit the cycle after ack+1.
- Reset mid-scan: all state returns to the reset values on the next edge. Bus ack in flight is dropped.

Decomposition:
- Package hex_scan_pkg holds:
  - Register addresses ADR_VALUE = 0, ADR_CTRL = 1.
  - CTRL bit positions.
  - Scan state encoding SHOW/GAP.
  - SEG_OFF = 7'h7f.
- One sub-module: the existing seg_7 decoder (num[3:0], en, seg[6:0]), instantiated once. Prescaler, FSM and bus logic stay inline.

Test Plan (SCAN_DIV = 4, BLINK_SLOTS = 2):
- Reset asserted 3 cycles, then released:
  - an_n_o = 4'hf, seg_o = 7'h7f, wb_ack_o = 0.
  - Read CTRL → 16'h0000.
- Write VALUE = 16'h1234 (sel = 2'b11), CTRL = 16'h0001:
  - Anodes cycle 4'b1110, 1101, 1011, 0111.
  - Each SHOW lasts 4 clocks and is separated by one all-off 4'hf clock.
  - seg_o shows the seg_7 codes for 4, 3, 2, 1.
- Write VALUE with sel = 2'b01, data 16'hABCD over 16'h1234:
  - Read-back = 16'h12CD.
  - Ack is high exactly one cycle per access; holding stb for 4 cycles gives acks on cycles 2 and 4.
- CTRL = 16'h0041 (BLANK[2]): slot for digit 2 has an_n_o = 4'b1011 with seg_o = 7'h7f; other digits are normal.
- CTRL = 16'h0003 (BLINK): segments are dark for 2 full slots and lit for 2 slots, alternating. Writing CTRL = 1 mid-dark relights on the next SHOW.
- Assert wb_rst_i during a SHOW of digit 2 with an ack pending:
  - Next cycle: an_n_o = 4'hf, wb_ack_o = 0, VALUE reads 0.
  - Scan restarts at digit 0 after the CTRL.EN rewrite.
